// File: rtl/pdp8l_rkdma_pkg.sv
// Shared types for the RK8JE data-break engine.
// Optional build macro: RKDMA_FIELD_INC_EN.
package pdp8l_rkdma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CYC,
        NEXT,
        DONE
    } rk_state_t;

    localparam int NWORDS_FULL = 256;
    localparam int NWORDS_HALF = 128;

    typedef logic [14:0] brk_addr_t;

    function automatic brk_addr_t mk_brk_addr(
        input logic [2:0]  f,
        input logic [11:0] a
    );
        return {f, a};
    endfunction

endpackage

// File: rtl/rkdma_bufram.sv
// 256 x 12 dual-port block buffer, registered reads.
// Port A belongs to the ARM, port B to the break engine.
module rkdma_bufram
    import pdp8l_rkdma_pkg::*;
(
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic [7:0]  a_addr,
    input  logic        a_we,
    input  logic [11:0] a_wdata,
    output logic [11:0] a_rdata,
    input  logic [7:0]  b_addr,
    input  logic        b_we,
    input  logic [11:0] b_wdata,
    output logic [11:0] b_rdata
);

    logic [11:0] mem [0:NWORDS_FULL-1];

    always_ff @(posedge CLOCK) begin
        if (a_we) mem[a_addr] <= a_wdata;
        if (b_we) mem[b_addr] <= b_wdata;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            a_rdata <= mem[a_addr];
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/pdp8l_rkdma.sv
// RK8JE data-break engine: moves one block between buffer and core.
// Build macro RKDMA_FIELD_INC_EN: field increments on address wrap.
module pdp8l_rkdma
    import pdp8l_rkdma_pkg::*;
#(
    parameter int BRK_TIMEOUT = 4095,
    parameter int NWORDS      = NWORDS_FULL
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        start,
    input  logic        abort,
    input  logic        wrmem,
    input  logic        halfblk,
    input  logic [2:0]  field,
    input  logic [11:0] memaddr_in,
    output logic        busy,
    output logic        xferdone,
    output logic        timedout,
    output logic [11:0] memaddr_out,
    output logic [8:0]  wordcnt,
    input  logic [7:0]  bufaddr,
    input  logic        bufwe,
    input  logic [11:0] bufwdata,
    output logic [11:0] bufrdata,
    output logic        BRK_RQST,
    input  logic        brkgrant,
    input  logic        brkdone,
    output logic [14:0] BRK_ADDR,
    output logic        BRK_WRITE,
    output logic [11:0] BRK_WDATA,
    input  logic [11:0] brkrdata
);

    localparam int TW = $clog2(BRK_TIMEOUT + 1);

    rk_state_t   state, state_n;
    logic        wr_q, half_q, abt_q, to_q;
    logic [2:0]  fld_q;
    logic [11:0] ma_q;
    logic [8:0]  wc_q, limit;
    logic [TW-1:0] tcnt;
    logic        go, commit, tmo, act;
    logic [7:0]  b_addr;
    logic        b_we;
    logic [11:0] b_rdata;

    assign limit = half_q ? 9'(NWORDS / 2) : 9'(NWORDS);

    always_comb begin
        state_n = state;
        go      = 1'b0;
        commit  = 1'b0;
        tmo     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n = REQ;
                    go      = 1'b1;
                end
            end
            REQ: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (brkgrant) begin
                    state_n = CYC;
                end else if (tcnt == TW'(BRK_TIMEOUT - 1)) begin
                    state_n = IDLE;
                    tmo     = 1'b1;
                end
            end
            // a granted core cycle always runs to brkdone
            CYC: begin
                if (brkdone) begin
                    commit  = 1'b1;
                    state_n = (abt_q || abort) ? IDLE : NEXT;
                end
            end
            NEXT: begin
                if (abort)              state_n = IDLE;
                else if (wc_q == limit) state_n = DONE;
                else                    state_n = REQ;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= IDLE;
            wr_q   <= 1'b0;
            half_q <= 1'b0;
            abt_q  <= 1'b0;
            to_q   <= 1'b0;
            fld_q  <= '0;
            ma_q   <= '0;
            wc_q   <= '0;
            tcnt   <= '0;
        end else begin
            state <= state_n;
            to_q  <= tmo;
            if (go) begin
                wr_q   <= wrmem;
                half_q <= halfblk;
                fld_q  <= field;
                ma_q   <= memaddr_in;
                wc_q   <= '0;
                abt_q  <= 1'b0;
            end
            if (state == CYC && abort) abt_q <= 1'b1;
            if (state_n == REQ && state != REQ) tcnt <= '0;
            else if (state == REQ)              tcnt <= tcnt + TW'(1);
            if (commit) begin
                ma_q <= ma_q + 12'd1;
                wc_q <= wc_q + 9'd1;
`ifdef RKDMA_FIELD_INC_EN
                if (ma_q == 12'o7777) fld_q <= fld_q + 3'd1;
`endif
            end
        end
    end

    assign act         = (state == REQ) || (state == CYC);
    assign busy        = state inside {REQ, CYC, NEXT};
    assign xferdone    = (state == DONE);
    assign timedout    = to_q;
    assign memaddr_out = ma_q;
    assign wordcnt     = wc_q;
    assign BRK_RQST    = (state == REQ);
    assign BRK_ADDR    = act ? mk_brk_addr(fld_q, ma_q) : '0;
    assign BRK_WRITE   = act & wr_q;
    assign BRK_WDATA   = (act & wr_q) ? b_rdata : '0;

    // word 0 is prefetched while idle so it is ready on the first grant
    assign b_addr = (state == IDLE) ? 8'd0 : wc_q[7:0];
    assign b_we   = commit & ~wr_q;

    rkdma_bufram u_buf (
        .CLOCK   (CLOCK),
        .RESET_N (RESET_N),
        .a_addr  (bufaddr),
        .a_we    (bufwe & ~busy),
        .a_wdata (bufwdata),
        .a_rdata (bufrdata),
        .b_addr  (b_addr),
        .b_we    (b_we),
        .b_wdata (brkrdata),
        .b_rdata (b_rdata)
    );

endmodule
